// File: rtl/requantize_pipe.sv
// requantize_pipe: two-stage, per-channel requantizer with valid/ready flow.
// Each sample keeps its nquant most-significant bits; dropped LSBs are rounded
// (truncate / half-up / half-even), saturated on round-up overflow, then zeroed
// so the result stays left-aligned at full width.
// Optional build macro REQUANTIZE_SATSTATS_EN adds a sticky 16-bit saturation
// event counter on sat_count (cleared by cnt_clr); without it sat_count is 0.
//
// Handshake: en = !dout_valid || dout_ready and din_ready = en. A sample
// transfers in on din_valid && din_ready and out on dout_valid && dout_ready.
// Both stages move only when en=1, bubbles are kept, and dout/dout_ch/dout_sat
// hold still while dout_valid && !dout_ready.
module requantize_pipe #(
   parameter  int DW     = 18,
   parameter  int NCH    = 4,
   parameter  int SIGNED = 0,
   localparam int NQW    = $clog2(DW + 1),
   localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           cfg_we,
   input  logic [CHW-1:0] cfg_ch,
   input  logic [NQW-1:0] cfg_nquant,
   input  logic [1:0]     cfg_mode,
   input  logic [DW-1:0]  din,
   input  logic [CHW-1:0] din_ch,
   input  logic           din_valid,
   output logic           din_ready,
   output logic [DW-1:0]  dout,
   output logic [CHW-1:0] dout_ch,
   output logic           dout_valid,
   input  logic           dout_ready,
   output logic           dout_sat,
   output logic [15:0]    sat_count,
   input  logic           cnt_clr
);

   // per-channel configuration
   logic [NQW-1:0] r_cfg_nq   [NCH];
   logic [1:0]     r_cfg_mode [NCH];

   // stage 1 registers
   logic           r_s1_valid;
   logic [CHW-1:0] r_s1_ch;
   logic [DW-1:0]  r_s1_kept;
   logic [NQW-1:0] r_s1_s;
   logic [1:0]     r_s1_mode;
   logic           r_s1_half;
   logic           r_s1_sticky;
   logic           r_s1_zero;

   // output stage registers
   logic           r_dout_valid;
   logic [DW-1:0]  r_dout;
   logic [CHW-1:0] r_dout_ch;
   logic           r_dout_sat;

   logic           w_en;
   logic [CHW-1:0] w_sel;
   logic [NQW-1:0] w_nq;
   logic [1:0]     w_mode;
   logic [NQW-1:0] w_s;
   logic [DW-1:0]  w_kept;
   logic           w_half;
   logic           w_sticky;
   logic           w_zero;

   logic           w_inc;
   logic [DW:0]    w_sum;
   logic [DW-1:0]  w_kmax;
   logic           w_ovf;
   logic [DW-1:0]  w_r;
   logic [DW-1:0]  w_dout;
   logic           w_sat;

   assign w_en      = !r_dout_valid || dout_ready;
   assign din_ready = w_en;

   // config write; out-of-range channel indices are dropped
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NCH; i++) begin
            r_cfg_nq[i]   <= NQW'(DW);
            r_cfg_mode[i] <= 2'd2;
         end
      end else if (cfg_we && (int'(cfg_ch) < NCH)) begin
         r_cfg_nq[cfg_ch]   <= cfg_nquant;
         r_cfg_mode[cfg_ch] <= cfg_mode;
      end
   end

   // stage 1 decode: select channel config, split kept / dropped bits
   always_comb begin
      w_sel    = (int'(din_ch) < NCH) ? din_ch : '0;
      w_nq     = r_cfg_nq[w_sel];
      w_mode   = r_cfg_mode[w_sel];
      w_zero   = (w_nq == '0);
      w_s      = (w_nq >= NQW'(DW)) ? '0 : NQW'(DW) - w_nq;
      w_half   = 1'b0;
      w_sticky = 1'b0;
      if (SIGNED != 0) begin
         w_kept = $signed(din) >>> w_s;
      end else begin
         w_kept = din >> w_s;
      end
      for (int i = 0; i < DW; i++) begin
         if (i + 1 == int'(w_s)) w_half = din[i];
         if (i + 1 < int'(w_s))  w_sticky = w_sticky | din[i];
      end
   end

   // stage 1 register, advances with the output stage
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_s1_valid  <= 1'b0;
         r_s1_ch     <= '0;
         r_s1_kept   <= '0;
         r_s1_s      <= '0;
         r_s1_mode   <= '0;
         r_s1_half   <= 1'b0;
         r_s1_sticky <= 1'b0;
         r_s1_zero   <= 1'b0;
      end else if (w_en) begin
         r_s1_valid <= din_valid;
         if (din_valid) begin
            r_s1_ch     <= din_ch;
            r_s1_kept   <= w_kept;
            r_s1_s      <= w_s;
            r_s1_mode   <= w_mode;
            r_s1_half   <= w_half;
            r_s1_sticky <= w_sticky;
            r_s1_zero   <= w_zero;
         end
      end
   end

   // stage 2: round increment, guarded add, saturate, re-align
   always_comb begin
      unique case (r_s1_mode)
         2'd1:    w_inc = r_s1_half;
         2'd2:    w_inc = r_s1_half && (r_s1_sticky || r_s1_kept[0]);
         default: w_inc = 1'b0;
      endcase
      if (SIGNED != 0) begin
         w_sum  = {r_s1_kept[DW-1], r_s1_kept} + {{DW{1'b0}}, w_inc};
         w_kmax = {DW{1'b1}} >> (int'(r_s1_s) + 1);
         w_ovf  = $signed(w_sum) > $signed({1'b0, w_kmax});
      end else begin
         w_sum  = {1'b0, r_s1_kept} + {{DW{1'b0}}, w_inc};
         w_kmax = {DW{1'b1}} >> r_s1_s;
         w_ovf  = w_sum > {1'b0, w_kmax};
      end
      w_r    = w_ovf ? w_kmax : w_sum[DW-1:0];
      w_dout = r_s1_zero ? '0 : (w_r << r_s1_s);
      w_sat  = w_ovf && !r_s1_zero;
   end

   // output register, held while downstream stalls
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_dout_valid <= 1'b0;
         r_dout       <= '0;
         r_dout_ch    <= '0;
         r_dout_sat   <= 1'b0;
      end else if (w_en) begin
         r_dout_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_dout     <= w_dout;
            r_dout_ch  <= r_s1_ch;
            r_dout_sat <= w_sat;
         end
      end
   end

   assign dout       = r_dout;
   assign dout_ch    = r_dout_ch;
   assign dout_valid = r_dout_valid;
   assign dout_sat   = r_dout_sat;

`ifdef REQUANTIZE_SATSTATS_EN
   logic [15:0] r_sat_count;

   // saturation event counter: clear wins, sticks at all-ones
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_sat_count <= '0;
      end else if (cnt_clr) begin
         r_sat_count <= '0;
      end else if (r_dout_valid && dout_ready && r_dout_sat && (r_sat_count != 16'hFFFF)) begin
         r_sat_count <= r_sat_count + 16'd1;
      end
   end

   assign sat_count = r_sat_count;
`else
   logic w_unused_cnt_clr;

   assign w_unused_cnt_clr = cnt_clr;
   assign sat_count        = '0;
`endif

endmodule

// File: tb/tb_requantize_pipe.sv
// Bench for requantize_pipe: an 18-bit unsigned 3-channel instance and an
// 8-bit signed 2-channel instance, each with an expected-result queue.
module tb_requantize_pipe;

   localparam int W = 64;

`ifdef REQUANTIZE_SATSTATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic clock;
   logic reset;

   // instance A: DW=18, NCH=3, unsigned
   logic        a_cfg_we;
   logic [1:0]  a_cfg_ch;
   logic [4:0]  a_cfg_nquant;
   logic [1:0]  a_cfg_mode;
   logic [17:0] a_din;
   logic [1:0]  a_din_ch;
   logic        a_din_valid;
   logic        a_din_ready;
   logic [17:0] a_dout;
   logic [1:0]  a_dout_ch;
   logic        a_dout_valid;
   logic        a_dout_ready;
   logic        a_dout_sat;
   logic [15:0] a_sat_count;
   logic        a_cnt_clr;

   // instance B: DW=8, NCH=2, signed
   logic        b_cfg_we;
   logic [0:0]  b_cfg_ch;
   logic [3:0]  b_cfg_nquant;
   logic [1:0]  b_cfg_mode;
   logic [7:0]  b_din;
   logic [0:0]  b_din_ch;
   logic        b_din_valid;
   logic        b_din_ready;
   logic [7:0]  b_dout;
   logic [0:0]  b_dout_ch;
   logic        b_dout_valid;
   logic        b_dout_ready;
   logic        b_dout_sat;
   logic [15:0] b_sat_count;
   logic        b_cnt_clr;

   logic [W-1:0] exp_q_a[$];
   logic [W-1:0] exp_q_b[$];

   int a_nq[4];
   int a_mode[4];
   int b_nq[2];
   int b_mode[2];

   int n_chk = 0;
   int n_err = 0;

   requantize_pipe #(.DW(18), .NCH(3), .SIGNED(0)) u_dut_a (
      .clock(clock), .reset(reset),
      .cfg_we(a_cfg_we), .cfg_ch(a_cfg_ch), .cfg_nquant(a_cfg_nquant), .cfg_mode(a_cfg_mode),
      .din(a_din), .din_ch(a_din_ch), .din_valid(a_din_valid), .din_ready(a_din_ready),
      .dout(a_dout), .dout_ch(a_dout_ch), .dout_valid(a_dout_valid), .dout_ready(a_dout_ready),
      .dout_sat(a_dout_sat), .sat_count(a_sat_count), .cnt_clr(a_cnt_clr)
   );

   requantize_pipe #(.DW(8), .NCH(2), .SIGNED(1)) u_dut_b (
      .clock(clock), .reset(reset),
      .cfg_we(b_cfg_we), .cfg_ch(b_cfg_ch), .cfg_nquant(b_cfg_nquant), .cfg_mode(b_cfg_mode),
      .din(b_din), .din_ch(b_din_ch), .din_valid(b_din_valid), .din_ready(b_din_ready),
      .dout(b_dout), .dout_ch(b_dout_ch), .dout_valid(b_dout_valid), .dout_ready(b_dout_ready),
      .dout_sat(b_dout_sat), .sat_count(b_sat_count), .cnt_clr(b_cnt_clr)
   );

   // clock / reset / watchdog
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // reference requantizer written as integer floor-divide plus remainder rounding
   function automatic logic [W-1:0] ref_q(input longint x_raw, input int dw, input bit sg,
                                          input int nq, input int mode, output bit sat);
      longint x, q, rem, half, maxq;
      int s;
      sat = 1'b0;
      if (nq == 0) return '0;
      s = (nq >= dw) ? 0 : dw - nq;
      x = x_raw;
      if (sg && x[dw-1]) x = x - (64'sd1 <<< dw);
      q   = x >>> s;
      rem = x - (q <<< s);
      if (s > 0) begin
         half = 64'sd1 <<< (s - 1);
         if (mode == 1 && rem >= half) q = q + 1;
         else if (mode == 2 && (rem > half || (rem == half && q[0]))) q = q + 1;
      end
      maxq = sg ? ((64'sd1 <<< (dw - s - 1)) - 1) : ((64'sd1 <<< (dw - s)) - 1);
      if (q > maxq) begin
         q   = maxq;
         sat = 1'b1;
      end
      return W'((q <<< s) & ((64'sd1 <<< dw) - 1));
   endfunction

   function automatic logic [W-1:0] pack_exp(input logic [31:0] d, input logic [7:0] ch, input bit sat);
      return {23'd0, sat, ch, d};
   endfunction

   task automatic reset_model();
      for (int i = 0; i < 4; i++) begin
         a_nq[i]   = 18;
         a_mode[i] = 2;
      end
      for (int i = 0; i < 2; i++) begin
         b_nq[i]   = 8;
         b_mode[i] = 2;
      end
   endtask

   // driver tasks
   task automatic cfg_a(input int ch, input int nq, input int mode);
      @(negedge clock);
      a_cfg_we = 1'b1; a_cfg_ch = 2'(ch); a_cfg_nquant = 5'(nq); a_cfg_mode = 2'(mode);
      @(posedge clock);
      #1 a_cfg_we = 1'b0;
      if (ch < 3) begin
         a_nq[ch]   = nq;
         a_mode[ch] = mode;
      end
   endtask

   task automatic cfg_b(input int ch, input int nq, input int mode);
      @(negedge clock);
      b_cfg_we = 1'b1; b_cfg_ch = 1'(ch); b_cfg_nquant = 4'(nq); b_cfg_mode = 2'(mode);
      @(posedge clock);
      #1 b_cfg_we = 1'b0;
      b_nq[ch]   = nq;
      b_mode[ch] = mode;
   endtask

   task automatic send_a(input logic [17:0] d, input int ch);
      int n;
      int sel;
      bit sat;
      logic [W-1:0] v;
      n = 0;
      @(negedge clock);
      a_din = d; a_din_ch = 2'(ch); a_din_valid = 1'b1;
      #1;
      while (!a_din_ready && n < 50) begin
         @(negedge clock);
         #1;
         n++;
      end
      if (!a_din_ready) begin
         chk("a_accept_timeout", 0, 1);
      end else begin
         sel = (ch < 3) ? ch : 0;
         v = ref_q(longint'(d), 18, 1'b0, a_nq[sel], a_mode[sel], sat);
         exp_q_a.push_back(pack_exp(v[31:0], 8'(ch), sat));
         @(posedge clock);
      end
      #1 a_din_valid = 1'b0;
   endtask

   task automatic send_b(input logic [7:0] d, input int ch);
      int n;
      bit sat;
      logic [W-1:0] v;
      n = 0;
      @(negedge clock);
      b_din = d; b_din_ch = 1'(ch); b_din_valid = 1'b1;
      #1;
      while (!b_din_ready && n < 50) begin
         @(negedge clock);
         #1;
         n++;
      end
      if (!b_din_ready) begin
         chk("b_accept_timeout", 0, 1);
      end else begin
         v = ref_q(longint'(d), 8, 1'b1, b_nq[ch], b_mode[ch], sat);
         exp_q_b.push_back(pack_exp(v[31:0], 8'(ch), sat));
         @(posedge clock);
      end
      #1 b_din_valid = 1'b0;
   endtask

   task automatic pulse_clr_a();
      @(negedge clock);
      a_cnt_clr = 1'b1;
      @(posedge clock);
      #1 a_cnt_clr = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while ((exp_q_a.size() != 0 || exp_q_b.size() != 0) && n < 100) begin
         @(posedge clock);
         n++;
      end
      chk(tag, W'(exp_q_a.size() + exp_q_b.size()), 0);
      @(posedge clock);
      #1;
   endtask

   // scoreboard: output transfers are sampled mid-cycle and popped against expectations
   always begin
      logic [W-1:0] e;
      @(negedge clock);
      #2;
      if (reset && a_dout_valid && a_dout_ready) begin
         if (exp_q_a.size() == 0) begin
            chk("a_unexpected_out", 1, 0);
         end else begin
            e = exp_q_a.pop_front();
            chk("a_dout", W'(a_dout), W'(e[31:0]));
            chk("a_dout_ch", W'(a_dout_ch), W'(e[39:32]));
            chk("a_dout_sat", W'(a_dout_sat), W'(e[40]));
         end
      end
      if (reset && b_dout_valid && b_dout_ready) begin
         if (exp_q_b.size() == 0) begin
            chk("b_unexpected_out", 1, 0);
         end else begin
            e = exp_q_b.pop_front();
            chk("b_dout", W'(b_dout), W'(e[31:0]));
            chk("b_dout_ch", W'(b_dout_ch), W'(e[39:32]));
            chk("b_dout_sat", W'(b_dout_sat), W'(e[40]));
         end
      end
   end

   // main sequence
   initial begin
      logic [17:0] d;
      reset = 1'b0;
      a_cfg_we = 0; a_cfg_ch = 0; a_cfg_nquant = 0; a_cfg_mode = 0;
      a_din = 0; a_din_ch = 0; a_din_valid = 0; a_dout_ready = 1; a_cnt_clr = 0;
      b_cfg_we = 0; b_cfg_ch = 0; b_cfg_nquant = 0; b_cfg_mode = 0;
      b_din = 0; b_din_ch = 0; b_din_valid = 0; b_dout_ready = 1; b_cnt_clr = 0;
      reset_model();
      repeat (3) @(posedge clock);
      #1;
      chk("rst_dout_valid", W'(a_dout_valid), 0);
      chk("rst_dout", W'(a_dout), 0);
      chk("rst_dout_ch", W'(a_dout_ch), 0);
      chk("rst_dout_sat", W'(a_dout_sat), 0);
      chk("rst_sat_count", W'(a_sat_count), 0);
      @(negedge clock);
      reset = 1'b1;

      // rounding modes at nquant=16
      cfg_a(0, 16, 0); send_a(18'h0000A, 0);
      cfg_a(0, 16, 1); send_a(18'h0000A, 0);
      cfg_a(0, 16, 2); send_a(18'h0000A, 0);
      send_a(18'h0000E, 0);
      send_a(18'h0000B, 0);
      drain("drain_modes");

      // saturation and its counter
      pulse_clr_a();
      cfg_a(0, 16, 1); send_a(18'h3FFFF, 0);
      drain("drain_sat");
      chk("sat_count_after_sat", W'(a_sat_count), STATS ? 1 : 0);
      pulse_clr_a();
      chk("sat_count_after_clr", W'(a_sat_count), 0);

      // boundaries: nquant 0, DW, above DW, 1; mode 3; ignored cfg write to ch3
      cfg_a(0, 0, 1);  send_a(18'h3FFFF, 0);
      cfg_a(0, 18, 1); send_a(18'h2AAAB, 0);
      cfg_a(0, 25, 2); send_a(18'h15557, 0);
      cfg_a(0, 1, 1);  send_a(18'h3FFFF, 0); send_a(18'h1FFFF, 0);
      cfg_a(0, 10, 3); send_a(18'h3FFFF, 0);
      cfg_a(3, 2, 0);  send_a(18'h12345, 3);
      drain("drain_bound");

      // signed instance
      cfg_b(0, 4, 2); send_b(8'hE8, 0);
      cfg_b(0, 4, 1); send_b(8'hE8, 0); send_b(8'h78, 0);
      cfg_b(1, 1, 1); send_b(8'h40, 1); send_b(8'hC0, 1);
      cfg_b(1, 5, 2); send_b(8'h94, 1);
      drain("drain_signed");

      // multi-channel stream with a mid-stream stall
      cfg_a(0, 16, 2); cfg_a(1, 12, 1); cfg_a(2, 8, 2);
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               d = 18'($urandom_range(0, 18'h3FFFF));
               send_a(d, i % 4);
            end
         end
         begin
            repeat (4) @(negedge clock);
            a_dout_ready = 1'b0;
            for (int k = 0; k < 3; k++) begin
               #1;
               chk("stall_din_ready", W'(a_din_ready), 0);
               @(negedge clock);
            end
            a_dout_ready = 1'b1;
         end
      join
      drain("drain_stream");

      // reset with two samples in flight
      cfg_a(1, 4, 1);
      send_a(18'($urandom_range(0, 18'h3FFFF)), 1);
      send_a(18'($urandom_range(0, 18'h3FFFF)), 2);
      reset = 1'b0;
      #1;
      chk("midrst_dout_valid", W'(a_dout_valid), 0);
      chk("midrst_sat_count", W'(a_sat_count), 0);
      exp_q_a.delete();
      reset_model();
      @(negedge clock);
      reset = 1'b1;
      send_a(18'h2B6C5, 1);
      chk("lat_not_yet", W'(a_dout_valid), 0);
      @(posedge clock);
      #1;
      chk("lat_two_cycles", W'(a_dout_valid), 1);
      chk("passthrough_after_rst", W'(a_dout), W'(18'h2B6C5));
      drain("drain_final");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
